// File: rtl/reg_native_if2apb4_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_native_if2apb4_if
// Description : APB4 bus bundle shared by the bridge (master side) and the
//               externally muxed completers (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_native_if2apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLV    = 4
);
  logic [NUM_SLV-1:0]      PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );
endinterface
`default_nettype wire

// File: rtl/reg_native_if2apb4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reg_native_if2apb4
// Description : Native req/ack register interface to APB4 bridge. One request
//               at a time, slave select decoded from the address, byte strobes,
//               protection, PSLVERR pass-through and ACCESS-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_native_if2apb4 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLV        = 4,
  parameter int SLV_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    req_vld,
  output logic                         req_rdy,
  input  wire logic                    wr_en,
  input  wire logic                    rd_en,
  input  wire logic [ADDR_WIDTH-1:0]   addr,
  input  wire logic [DATA_WIDTH-1:0]   wr_data,
  input  wire logic [DATA_WIDTH/8-1:0] wr_strb,
  input  wire logic [2:0]              prot,
  output logic                         ack_vld,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         err,
  reg_native_if2apb4_if.master         apb
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [SEL_W-1:0]        idx;
  logic                    bad_idx;
  logic [NUM_SLV-1:0]      sel_dec;
  logic                    tmo_hit;

  logic                    accept;
  logic                    start;
  logic                    bad_req;
  logic                    done;
  logic                    tmo;

  logic [NUM_SLV-1:0]      psel;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [CNT_W-1:0]        wait_cnt;

  assign idx = addr[SLV_LSB +: SEL_W];

  // Slave decode: only a non power-of-two slave count can yield an unmapped index
  generate
    if (NUM_SLV == 1) begin : g_single
      assign bad_idx = 1'b0;
      assign sel_dec = 1'b1;
    end else begin : g_multi
      if (NUM_SLV == (1 << SEL_W)) begin : g_full
        assign bad_idx = 1'b0;
      end else begin : g_partial
        assign bad_idx = (idx >= SEL_W'(NUM_SLV));
      end
      assign sel_dec = NUM_SLV'(1) << idx;
    end
  endgenerate

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive low-PREADY ACCESS cycle
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  assign req_rdy     = (state == IDLE);
  assign apb.PSEL    = psel;
  assign apb.PENABLE = (state == ACCESS);
  assign apb.PWRITE  = pwrite;
  assign apb.PADDR   = paddr;
  assign apb.PWDATA  = pwdata;
  assign apb.PSTRB   = pstrb;
  assign apb.PPROT   = pprot;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle transfer events
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start     = 1'b0;
    bad_req   = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (req_vld) begin
          accept = 1'b1;
          if ((wr_en == rd_en) || bad_idx) begin
            bad_req = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (apb.PREADY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields; reads drive an all-zero strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (accept) begin
      pwrite <= wr_en;
      paddr  <= addr;
      pwdata <= wr_data;
      pstrb  <= wr_en ? wr_strb : '0;
      pprot  <= prot;
    end
  end

  // Slave select asserted through SETUP/ACCESS, dropped on completion or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            psel <= '0;
    else if (start)        psel <= sel_dec;
    else if (done || tmo)  psel <= '0;
  end

  // ACCESS wait counter: cleared on SETUP entry, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !apb.PREADY && (wait_cnt != {CNT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Single-cycle registered response; data and error are zero outside the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_vld <= 1'b0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      ack_vld <= done | tmo | bad_req;
      err     <= bad_req | tmo | (done & apb.PSLVERR);
      rd_data <= (done && !pwrite && !apb.PSLVERR) ? apb.PRDATA : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_native_if2apb4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_native_if2apb4
// Description : Self-checking bench for reg_native_if2apb4 (3 slaves,
//               4-cycle timeout) with directed and random transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_native_if2apb4;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int LSB = 12;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld, req_rdy, wr_en, rd_en;
  logic [31:0] addr, wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic [2:0]  prot;
  logic        ack_vld, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_native_if2apb4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS)) apb ();

  reg_native_if2apb4 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLV(NS),
    .SLV_LSB(LSB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .prot(prot),
    .ack_vld(ack_vld), .rd_data(rd_data), .err(err),
    .apb(apb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transfer; expectations come from the request and the completer's wait plan.
  // Called at a point where req_rdy is expected high (just after a clock edge).
  task automatic xfer(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input int waits, input logic [31:0] prd, input logic slverr,
                      output time t_acc);
    int          slot, exp_acc, exp_lat, k, acc;
    bit          legal, tmo, got;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [2:0]  exp_sel;
    slot    = int'(a[LSB +: 2]);
    legal   = (w != r) && (slot < NS);
    tmo     = legal && (waits >= TMO);
    exp_acc = !legal ? 0 : (tmo ? TMO : waits + 1);
    exp_lat = !legal ? 1 : exp_acc + 2;
    exp_err = !legal || tmo || slverr;
    exp_rd  = (legal && !tmo && r && !slverr) ? prd : 32'h0;
    exp_sel = legal ? 3'(1 << slot) : 3'b000;

    check("req_rdy_idle", req_rdy, 1);
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a;
    wr_data = wd; wr_strb = st; prot = pr;
    @(posedge clk);
    t_acc = $time;
    #1;
    req_vld = 1'b0;
    k = 1; acc = 0; got = 0;
    while (!got && k <= 40) begin
      if (k == 1) begin
        check("psel_setup", apb.PSEL, exp_sel);
        check("penable_setup", apb.PENABLE, 0);
        if (legal) begin
          check("pwrite", apb.PWRITE, w);
          check("paddr", apb.PADDR, a);
          check("pwdata", apb.PWDATA, wd);
          check("pstrb", apb.PSTRB, w ? st : 4'h0);
          check("pprot", apb.PPROT, pr);
        end
      end
      if (ack_vld) begin
        got = 1;
        apb.PREADY = 1'b0;
        check("ack_latency", k, exp_lat);
        check("access_cycles", acc, exp_acc);
        check("ack_err", err, exp_err);
        check("ack_rd_data", rd_data, exp_rd);
        check("psel_after", apb.PSEL, 0);
        check("penable_after", apb.PENABLE, 0);
        check("req_rdy_ack", req_rdy, 1);
      end else begin
        check("quiet_resp", {err, rd_data}, 0);
        if (apb.PENABLE) begin
          acc++;
          check("psel_access", apb.PSEL, exp_sel);
          check("paddr_hold", apb.PADDR, a);
          apb.PREADY  = (acc > waits);
          apb.PSLVERR = (acc > waits) ? slverr : 1'b0;
          apb.PRDATA  = prd;
        end else begin
          apb.PREADY = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (!got) check("ack_seen", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    logic w, r;
    logic [31:0] a;
    int p;
    req_vld = 0; wr_en = 0; rd_en = 0; addr = 0; wr_data = 0; wr_strb = 0; prot = 0;
    apb.PREADY = 0; apb.PSLVERR = 0; apb.PRDATA = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy", req_rdy, 1);
    check("rst_ack", ack_vld, 0);
    check("rst_resp", {err, rd_data}, 0);
    check("rst_psel", apb.PSEL, 0);
    check("rst_penable", apb.PENABLE, 0);
    check("rst_pwrite", apb.PWRITE, 0);
    check("rst_paddr", apb.PADDR, 0);
    check("rst_pwdata", apb.PWDATA, 0);
    check("rst_pstrb_pprot", {apb.PSTRB, apb.PPROT}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed transfers
    xfer(1, 0, 32'h0000_2010, 32'hDEAD_BEEF, 4'b0011, 3'b010, 0, 32'h0, 0, t1);
    xfer(0, 1, 32'h0000_1004, 32'h0, 4'hF, 3'b000, 3, 32'h1234_5678, 0, t1);
    xfer(0, 1, 32'h0000_0008, 32'h0, 4'h0, 3'b001, 1, 32'hFFFF_FFFF, 1, t1);
    xfer(0, 1, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 50, 32'hAAAA_5555, 0, t1);
    xfer(0, 1, 32'h0000_2000, 32'h0, 4'h0, 3'b000, TMO - 1, 32'h0BAD_F00D, 0, t1);
    xfer(1, 0, 32'h0000_3000, 32'h1111_2222, 4'hF, 3'b000, 0, 32'h0, 0, t1);
    xfer(1, 1, 32'h0000_1000, 32'h3333_4444, 4'hF, 3'b000, 0, 32'h0, 0, t1);
    xfer(0, 0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 0, 32'h0, 0, t1);

    // Reset during ACCESS
    req_vld = 1'b1; wr_en = 1'b0; rd_en = 1'b1; addr = 32'h0000_1020; prot = 3'b100;
    apb.PREADY = 1'b0;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_penable", apb.PENABLE, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_psel", apb.PSEL, 0);
    check("async_penable", apb.PENABLE, 0);
    check("async_ack", ack_vld, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_ack", ack_vld, 0);
      check("post_rst_rdy", req_rdy, 1);
    end

    // Back-to-back zero-wait transfers
    xfer(1, 0, 32'h0000_0100, 32'hCAFE_0001, 4'b1100, 3'b011, 0, 32'h0, 0, t1);
    xfer(0, 1, 32'h0000_2104, 32'h0, 4'h0, 3'b000, 0, 32'h5A5A_A5A5, 0, t2);
    check("b2b_spacing", t2 - t1, 30);

    // Random transfers
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 9);
      if (p == 0)      begin w = 1; r = 1; end
      else if (p == 1) begin w = 0; r = 0; end
      else begin w = 1'($urandom_range(0, 1)); r = !w; end
      a = $urandom;
      a[LSB +: 2] = 2'($urandom_range(0, 3));
      xfer(w, r, a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 5),
           $urandom, ($urandom_range(0, 4) == 0), t1);
    end

    @(posedge clk);
    #1;
    check("final_quiet", {ack_vld, err, rd_data}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
